// File: rtl/phy_cfg.sv
`default_nettype none
// ============================================================================
// phy_cfg : programs PHY advertisement/control over MDIO, then polls link/speed
// Revision: 1.0
// ============================================================================
module phy_cfg #(
  parameter int unsigned POLL_DIV = 250000,
  parameter int unsigned TIMEOUT  = 127
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        allow_1gbit,
  output logic [4:0]  addr,
  output logic [15:0] wr_data,
  output logic        rd_request,
  output logic        wr_request,
  input  logic        ready,
  input  logic [15:0] rd_data,
  output logic        link_up,
  output logic [1:0]  speed,
  output logic        config_done,
  output logic        mdio_fault
);

  typedef enum logic [1:0] {
    S_ISSUE     = 2'd0,
    S_ACCEPT    = 2'd1,
    S_DONE      = 2'd2,
    S_POLL_WAIT = 2'd3
  } state_t;

  localparam logic [23:0] POLL_LOAD = 24'(POLL_DIV - 1);
  localparam logic [7:0]  TO_LAST   = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [4:0]  addr_q, addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        rd_req_q, rd_req_d;
  logic        wr_req_q, wr_req_d;
  logic        link_up_q, link_up_d;
  logic [1:0]  speed_q, speed_d;
  logic        config_done_q, config_done_d;
  logic        mdio_fault_q, mdio_fault_d;
  logic [23:0] poll_cnt_q, poll_cnt_d;
  logic [7:0]  to_cnt_q, to_cnt_d;
  logic        allow_q, allow_d;
  logic        pending_q, pending_d;

  logic [4:0]  step_addr;
  logic [15:0] step_wdata;
  logic        enter_issue;
  logic        fault;
  logic        timed_out;

  // rd_data bits outside the link and speed fields are not decoded
  logic        unused_rd_bits;
  assign unused_rd_bits = ^{rd_data[13:3], rd_data[1:0]};

  always_comb begin
    step_addr  = 5'd0;
    step_wdata = 16'h0000;
    case (step_q)
      2'd0: begin
        step_addr  = 5'd9;
        step_wdata = allow_q ? 16'h0300 : 16'h0000;
      end
      2'd1: begin
        step_addr  = 5'd0;
        step_wdata = 16'h1200;
      end
      2'd2:    step_addr = 5'd1;
      default: step_addr = 5'd17;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    addr_d        = addr_q;
    wr_data_d     = wr_data_q;
    rd_req_d      = rd_req_q;
    wr_req_d      = wr_req_q;
    link_up_d     = link_up_q;
    speed_d       = speed_q;
    config_done_d = config_done_q;
    mdio_fault_d  = mdio_fault_q;
    poll_cnt_d    = poll_cnt_q;
    to_cnt_d      = 8'd0;
    allow_d       = allow_1gbit;
    pending_d     = pending_q | (allow_q != allow_1gbit);
    enter_issue   = 1'b0;
    fault         = 1'b0;
    timed_out     = (to_cnt_q == TO_LAST);

    case (state_q)
      S_ISSUE: begin
        if (ready) begin
          state_d   = S_ACCEPT;
          addr_d    = step_addr;
          wr_data_d = step_wdata;
          wr_req_d  = ~step_q[1];
          rd_req_d  = step_q[1];
        end
      end
      S_ACCEPT: begin
        if (!ready) begin
          state_d  = S_DONE;
          rd_req_d = 1'b0;
          wr_req_d = 1'b0;
        end else if (timed_out) begin
          fault = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        if (ready) begin
          case (step_q)
            2'd0: step_d = 2'd1;
            2'd1: begin
              step_d        = 2'd2;
              config_done_d = 1'b1;
            end
            2'd2: begin
              step_d    = 2'd3;
              link_up_d = rd_data[2];
            end
            default: begin
              step_d     = 2'd2;
              state_d    = S_POLL_WAIT;
              poll_cnt_d = POLL_LOAD;
              // A reserved speed code keeps the previous speed
              if (!link_up_q)
                speed_d = 2'b00;
              else if (rd_data[15:14] != 2'b11)
                speed_d = rd_data[15:14];
            end
          endcase
          if (step_q != 2'd3) begin
            state_d     = S_ISSUE;
            enter_issue = 1'b1;
          end
        end else if (timed_out) begin
          fault = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end
      default: begin
        if (poll_cnt_q == 24'd0) begin
          state_d     = S_ISSUE;
          enter_issue = 1'b1;
        end else begin
          poll_cnt_d = poll_cnt_q - 24'd1;
        end
      end
    endcase

    if (enter_issue && pending_d) begin
      step_d        = 2'd0;
      config_done_d = 1'b0;
      pending_d     = 1'b0;
    end

    if (fault) begin
      state_d       = S_ISSUE;
      step_d        = 2'd0;
      rd_req_d      = 1'b0;
      wr_req_d      = 1'b0;
      mdio_fault_d  = 1'b1;
      link_up_d     = 1'b0;
      config_done_d = 1'b0;
      pending_d     = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_ISSUE;
      step_q        <= 2'd0;
      addr_q        <= 5'd0;
      wr_data_q     <= 16'h0000;
      rd_req_q      <= 1'b0;
      wr_req_q      <= 1'b0;
      link_up_q     <= 1'b0;
      speed_q       <= 2'b00;
      config_done_q <= 1'b0;
      mdio_fault_q  <= 1'b0;
      poll_cnt_q    <= 24'd0;
      to_cnt_q      <= 8'd0;
      pending_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      addr_q        <= addr_d;
      wr_data_q     <= wr_data_d;
      rd_req_q      <= rd_req_d;
      wr_req_q      <= wr_req_d;
      link_up_q     <= link_up_d;
      speed_q       <= speed_d;
      config_done_q <= config_done_d;
      mdio_fault_q  <= mdio_fault_d;
      poll_cnt_q    <= poll_cnt_d;
      to_cnt_q      <= to_cnt_d;
      pending_q     <= pending_d;
    end
  end

  // Tracks the input through reset so a level held across reset is not seen as a change
  always_ff @(posedge clock) begin
    allow_q <= allow_d;
  end

  assign addr        = addr_q;
  assign wr_data     = wr_data_q;
  assign rd_request  = rd_req_q;
  assign wr_request  = wr_req_q;
  assign link_up     = link_up_q;
  assign speed       = speed_q;
  assign config_done = config_done_q;
  assign mdio_fault  = mdio_fault_q;

endmodule
`default_nettype wire

// File: tb/tb_phy_cfg.sv
`default_nettype none
// ============================================================================
// tb_phy_cfg : directed bench for phy_cfg with a behavioural MDIO engine/PHY
// Revision: 1.0
// ============================================================================
module tb_phy_cfg;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        allow_1gbit = 1'b1;
  logic [4:0]  addr;
  logic [15:0] wr_data;
  logic        rd_request;
  logic        wr_request;
  logic        ready = 1'b1;
  logic [15:0] rd_data = 16'h0000;
  logic        link_up;
  logic [1:0]  speed;
  logic        config_done;
  logic        mdio_fault;

  int tests = 0;
  int fails = 0;

  phy_cfg #(.POLL_DIV(16), .TIMEOUT(127)) dut (
    .clock       (clock),
    .reset       (reset),
    .allow_1gbit (allow_1gbit),
    .addr        (addr),
    .wr_data     (wr_data),
    .rd_request  (rd_request),
    .wr_request  (wr_request),
    .ready       (ready),
    .rd_data     (rd_data),
    .link_up     (link_up),
    .speed       (speed),
    .config_done (config_done),
    .mdio_fault  (mdio_fault)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit          is_wr;
    logic [4:0]  a;
    logic [15:0] d;
    int          gap;
  } txn_t;

  txn_t        log_q[$];
  txn_t        mt;
  int          busy_len = 3;
  int          busy_cnt = 0;
  int          ack_lag = 0;
  int          lag_cnt = 0;
  bit          ignore = 0;
  int          done_cnt = 0;
  int          last_done_cyc = 0;
  bit          overlap = 0;
  logic [15:0] reg1_val = 16'h796D;
  logic [15:0] reg17_val = 16'hBC00;

  // MDIO engine + PHY register model, sampling requests on negedge
  always @(negedge clock) begin
    if (rd_request && wr_request) overlap = 1;
    if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
      if (busy_cnt == 0) begin
        ready = 1'b1;
        done_cnt = done_cnt + 1;
        last_done_cyc = cyc + 1;
      end
    end else if (!ignore && ready && (rd_request || wr_request)) begin
      if (lag_cnt < ack_lag) begin
        lag_cnt = lag_cnt + 1;
      end else begin
        lag_cnt = 0;
        ready = 1'b0;
        busy_cnt = busy_len;
        if (rd_request)
          rd_data = (addr == 5'd1) ? reg1_val : (addr == 5'd17) ? reg17_val : 16'hDEAD;
        mt.is_wr = wr_request;
        mt.a = addr;
        mt.d = wr_data;
        mt.gap = cyc - last_done_cyc;
        log_q.push_back(mt);
      end
    end else if (!(rd_request || wr_request)) begin
      lag_cnt = 0;
    end
  end

  task automatic next_txn(output txn_t t);
    int n;
    n = 0;
    while (log_q.size() == 0 && n < 400) begin
      @(negedge clock); #1;
      n++;
    end
    tests++;
    t.is_wr = 0; t.a = 0; t.d = 0; t.gap = 0;
    if (log_q.size() == 0) begin
      fails++;
      $display("FAIL txn_wait: got no transaction, required one within 400 clocks");
    end else begin
      t = log_q.pop_front();
    end
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 400) begin
      @(negedge clock); #1;
      n++;
    end
    tests++;
    if (done_cnt < target) begin
      fails++;
      $display("FAIL done_wait: got %0d completions, required %0d", done_cnt, target);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    @(posedge clock); #1;
    tests += 8;
    if (addr !== 5'd0)        begin fails++; $display("FAIL rst_addr: got %h required 00", addr); end
    if (wr_data !== 16'h0)    begin fails++; $display("FAIL rst_wr_data: got %h required 0000", wr_data); end
    if (rd_request !== 1'b0)  begin fails++; $display("FAIL rst_rd_req: got %b required 0", rd_request); end
    if (wr_request !== 1'b0)  begin fails++; $display("FAIL rst_wr_req: got %b required 0", wr_request); end
    if (link_up !== 1'b0)     begin fails++; $display("FAIL rst_link: got %b required 0", link_up); end
    if (speed !== 2'b00)      begin fails++; $display("FAIL rst_speed: got %b required 00", speed); end
    if (config_done !== 1'b0) begin fails++; $display("FAIL rst_cfg_done: got %b required 0", config_done); end
    if (mdio_fault !== 1'b0)  begin fails++; $display("FAIL rst_fault: got %b required 0", mdio_fault); end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    tests++;
    if (wr_request !== 1'b1 || rd_request !== 1'b0 || addr !== 5'd9 || wr_data !== 16'h0300) begin
      fails++;
      $display("FAIL first_req: got wr=%b rd=%b addr=%0d data=%h required wr=1 rd=0 addr=9 data=0300",
               wr_request, rd_request, addr, wr_data);
    end
  endtask

  task automatic test_config();
    txn_t t;
    int base;
    int n;
    base = done_cnt;
    n = 0;
    while (done_cnt < base + 2 && n < 200) begin
      @(negedge clock); #1;
      n++;
    end
    tests++;
    if (config_done !== 1'b0) begin fails++; $display("FAIL cfg_done_early: got %b required 0", config_done); end
    @(posedge clock); #1;
    tests++;
    if (config_done !== 1'b1) begin fails++; $display("FAIL cfg_done_set: got %b required 1", config_done); end
    next_txn(t);
    tests++;
    if (!t.is_wr || t.a !== 5'd9 || t.d !== 16'h0300) begin
      fails++; $display("FAIL cfg_w9: got wr=%b addr=%0d data=%h required wr=1 addr=9 data=0300", t.is_wr, t.a, t.d);
    end
    next_txn(t);
    tests++;
    if (!t.is_wr || t.a !== 5'd0 || t.d !== 16'h1200) begin
      fails++; $display("FAIL cfg_w0: got wr=%b addr=%0d data=%h required wr=1 addr=0 data=1200", t.is_wr, t.a, t.d);
    end
    next_txn(t);
    tests++;
    if (t.is_wr || t.a !== 5'd1) begin
      fails++; $display("FAIL cfg_r1: got wr=%b addr=%0d required wr=0 addr=1", t.is_wr, t.a);
    end
    next_txn(t);
    tests++;
    if (t.is_wr || t.a !== 5'd17) begin
      fails++; $display("FAIL cfg_r17: got wr=%b addr=%0d required wr=0 addr=17", t.is_wr, t.a);
    end
    wait_done(base + 4);
    tests++;
    if (link_up !== 1'b1 || speed !== 2'b10) begin
      fails++; $display("FAIL cfg_status: got link=%b speed=%b required link=1 speed=10", link_up, speed);
    end
  endtask

  task automatic test_poll_period();
    txn_t t;
    next_txn(t);
    tests++;
    if (t.is_wr || t.a !== 5'd1 || t.gap != 17) begin
      fails++; $display("FAIL poll_gap: got wr=%b addr=%0d gap=%0d required wr=0 addr=1 gap=17", t.is_wr, t.a, t.gap);
    end
    reg1_val = 16'h7969;
    next_txn(t);
    wait_done(done_cnt + 1);
  endtask

  task automatic test_link_down();
    txn_t t;
    next_txn(t);
    wait_done(done_cnt + 1);
    tests++;
    if (link_up !== 1'b0 || speed !== 2'b10) begin
      fails++; $display("FAIL link_down_r1: got link=%b speed=%b required link=0 speed=10", link_up, speed);
    end
    next_txn(t);
    wait_done(done_cnt + 1);
    tests++;
    if (speed !== 2'b00) begin fails++; $display("FAIL link_down_speed: got %b required 00", speed); end
  endtask

  task automatic test_speed();
    txn_t t;
    reg1_val = 16'h796D;
    reg17_val = 16'h4000;
    next_txn(t);
    next_txn(t);
    reg17_val = 16'hC000;
    wait_done(done_cnt + 1);
    tests++;
    if (link_up !== 1'b1 || speed !== 2'b01) begin
      fails++; $display("FAIL speed_100: got link=%b speed=%b required link=1 speed=01", link_up, speed);
    end
    next_txn(t);
    next_txn(t);
    wait_done(done_cnt + 1);
    tests++;
    if (speed !== 2'b01) begin fails++; $display("FAIL speed_hold: got %b required 01", speed); end
  endtask

  task automatic test_reconfig();
    txn_t t;
    reg17_val = 16'hBC00;
    next_txn(t);
    next_txn(t);
    allow_1gbit = 1'b0;
    next_txn(t);
    tests++;
    if (!t.is_wr || t.a !== 5'd9 || t.d !== 16'h0000) begin
      fails++; $display("FAIL reconf_w9: got wr=%b addr=%0d data=%h required wr=1 addr=9 data=0000", t.is_wr, t.a, t.d);
    end
    tests++;
    if (config_done !== 1'b0) begin fails++; $display("FAIL reconf_cfg_drop: got %b required 0", config_done); end
    next_txn(t);
    tests++;
    if (!t.is_wr || t.a !== 5'd0 || t.d !== 16'h1200) begin
      fails++; $display("FAIL reconf_w0: got wr=%b addr=%0d data=%h required wr=1 addr=0 data=1200", t.is_wr, t.a, t.d);
    end
    next_txn(t);
    next_txn(t);
    wait_done(done_cnt + 1);
    tests++;
    if (config_done !== 1'b1 || link_up !== 1'b1 || speed !== 2'b10) begin
      fails++; $display("FAIL reconf_final: got cfg=%b link=%b speed=%b required cfg=1 link=1 speed=10",
                        config_done, link_up, speed);
    end
  endtask

  task automatic test_timeout();
    bit found;
    int width;
    ignore = 1;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #1;
      if (rd_request || wr_request) begin found = 1; break; end
    end
    tests++;
    if (!found || rd_request !== 1'b1 || addr !== 5'd1) begin
      fails++; $display("FAIL to_req: got found=%b rd=%b addr=%0d required found=1 rd=1 addr=1", found, rd_request, addr);
    end
    width = 0;
    while ((rd_request || wr_request) && width < 300) begin
      width++;
      @(posedge clock); #1;
    end
    tests++;
    if (width != 127) begin fails++; $display("FAIL to_width: got %0d clocks required 127", width); end
    tests++;
    if (mdio_fault !== 1'b1 || link_up !== 1'b0 || config_done !== 1'b0) begin
      fails++; $display("FAIL to_flags: got fault=%b link=%b cfg=%b required fault=1 link=0 cfg=0",
                        mdio_fault, link_up, config_done);
    end
    @(posedge clock); #1;
    tests++;
    if (wr_request !== 1'b1 || addr !== 5'd9 || wr_data !== 16'h0000) begin
      fails++; $display("FAIL to_restart: got wr=%b addr=%0d data=%h required wr=1 addr=9 data=0000",
                        wr_request, addr, wr_data);
    end
    @(negedge clock);
    ignore = 0;
    log_q.delete();
  endtask

  task automatic test_reset_mid();
    txn_t t;
    bit got;
    bit late;
    busy_len = 40;
    for (int i = 0; i < 4; i++) begin
      next_txn(t);
      if (!t.is_wr) break;
    end
    repeat (20) @(negedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    tests++;
    if (rd_request !== 1'b0 || wr_request !== 1'b0) begin
      fails++; $display("FAIL rstmid_req: got rd=%b wr=%b required 0 0", rd_request, wr_request);
    end
    repeat (2) @(posedge clock);
    #1;
    tests++;
    if (addr !== 5'd0 || wr_data !== 16'h0 || link_up !== 1'b0 || speed !== 2'b00 ||
        config_done !== 1'b0 || mdio_fault !== 1'b0) begin
      fails++; $display("FAIL rstmid_outs: got addr=%0d data=%h link=%b speed=%b cfg=%b fault=%b required all zero",
                        addr, wr_data, link_up, speed, config_done, mdio_fault);
    end
    @(negedge clock);
    reset = 1'b0;
    busy_len = 3;
    got = 0;
    late = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #1;
      if (rd_request || wr_request) begin got = 1; break; end
      if (ready) late = 1;
    end
    tests++;
    if (!got || late || wr_request !== 1'b1 || addr !== 5'd9 || wr_data !== 16'h0000 || ready !== 1'b1) begin
      fails++; $display("FAIL rstmid_reissue: got found=%b late=%b rdy=%b wr=%b addr=%0d data=%h required 1 0 1 1 9 0000",
                        got, late, ready, wr_request, addr, wr_data);
    end
    ack_lag = 10;
    @(negedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    tests++;
    if (rd_request !== 1'b0 || wr_request !== 1'b0) begin
      fails++; $display("FAIL rst_drop_req: got rd=%b wr=%b required 0 0", rd_request, wr_request);
    end
    @(negedge clock);
    reset = 1'b0;
    ack_lag = 0;
    @(posedge clock); #1;
    tests++;
    if (wr_request !== 1'b1 || addr !== 5'd9) begin
      fails++; $display("FAIL rst_drop_reissue: got wr=%b addr=%0d required wr=1 addr=9", wr_request, addr);
    end
  endtask

  initial begin
    repeat (3) @(posedge clock);
    test_reset();
    test_config();
    test_poll_period();
    test_link_down();
    test_speed();
    test_reconfig();
    test_timeout();
    test_reset_mid();
    repeat (10) @(posedge clock);
    tests++;
    if (overlap) begin fails++; $display("FAIL req_overlap: got rd and wr high together, required never"); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
